// File: rtl/addsub_pkg.sv
// ============================================================================
// Module      : addsub_pkg
// Description : Shared types and helpers for the digit-serial adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package addsub_pkg;

   // Control states of the serial adder
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Result flags, latched together with the result
   typedef struct packed {
      logic cout;
      logic overflow;
      logic zero;
      logic negative;
   } flags_t;

   // Ceiling log2, used to size the digit counter
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/digit_adder.sv
// ============================================================================
// Module      : digit_adder
// Description : Combinational ripple of DIGIT full adders. Also exposes the
//               carry into the top bit so the caller can derive signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module digit_adder #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] sum,
   output logic             cout,
   output logic             c_msb
);

   // Ripple the carry through the digit, noting the carry entering the top bit
   always_comb begin
      logic carry;
      carry = cin;
      c_msb = cin;
      sum   = '0;
      for (int i = 0; i < DIGIT; i++) begin
         if (i == DIGIT - 1) begin
            c_msb = carry;
         end
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      cout = carry;
   end

endmodule

`default_nettype wire

// File: rtl/seq_addsub.sv
// ============================================================================
// Module      : seq_addsub
// Description : Digit-serial two's-complement adder/subtractor with valid/ready
//               handshakes. WIDTH-bit operands, DIGIT bits per clock, so one
//               operation takes WIDTH/DIGIT RUN cycles.
//               Optional macro SEQ_ADDSUB_SATURATE_EN clamps the result on
//               signed overflow instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);

   localparam int c_n     = WIDTH / DIGIT;
   localparam int c_cnt_w = (c_n > 1) ? clog2(c_n) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_n - 1);

   // Reject parameter sets that do not split into whole digits
   if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
      $error("seq_addsub: WIDTH must be a positive multiple of DIGIT");
   end

   state_e             r_state;
   state_e             w_state_next;
   logic [c_cnt_w-1:0] r_cnt;
   logic [WIDTH-1:0]   r_a;         // operand A, consumed LSB digit first
   logic [WIDTH-1:0]   r_b;         // effective operand B (already inverted for subtract)
   logic [WIDTH-1:0]   r_acc;       // partial sum, filled from the top down
   logic               r_carry;
   logic [WIDTH-1:0]   r_result;
   flags_t             r_flags;

   logic [DIGIT-1:0]   w_sum;
   logic               w_cout;
   logic               w_c_msb;
   logic               w_ovf;
   logic [WIDTH-1:0]   w_acc_next;
   logic [WIDTH-1:0]   w_final;
   logic               w_last;

   digit_adder #(
      .DIGIT (DIGIT)
   ) u_digit_adder (
      .a     (r_a[DIGIT-1:0]),
      .b     (r_b[DIGIT-1:0]),
      .cin   (r_carry),
      .sum   (w_sum),
      .cout  (w_cout),
      .c_msb (w_c_msb)
   );

   assign w_last     = (r_cnt == c_cnt_last);
   assign w_ovf      = w_c_msb ^ w_cout;
   // New digit enters at the top; after N shifts digit 0 sits at the bottom
   assign w_acc_next = (r_acc >> DIGIT) | (WIDTH'(w_sum) << (WIDTH - DIGIT));

   // Final result, clamped on overflow when saturation is built in
   always_comb begin
      w_final = w_acc_next;
`ifdef SEQ_ADDSUB_SATURATE_EN
      // On overflow both addends share a sign; the top bit of the last B digit
      // is that sign, so 0 means the true result is positive
      if (w_ovf) begin
         if (r_b[DIGIT-1]) begin
            w_final = {1'b1, {(WIDTH-1){1'b0}}};
         end else begin
            w_final = {1'b0, {(WIDTH-1){1'b1}}};
         end
      end
`endif
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and handshake outputs
   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_state_next = RUN;
            end
         end
         RUN: begin
            if (w_last) begin
               w_state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Operand capture, digit-serial accumulation and result/flag latch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_carry  <= 1'b0;
         r_result <= '0;
         r_flags  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_b     <= b ^ {WIDTH{sub}};
                  r_carry <= sub;
                  r_cnt   <= '0;
               end
            end
            RUN: begin
               r_a     <= r_a >> DIGIT;
               r_b     <= r_b >> DIGIT;
               r_acc   <= w_acc_next;
               r_carry <= w_cout;
               r_cnt   <= r_cnt + 1'b1;
               if (w_last) begin
                  r_result          <= w_final;
                  r_flags.cout      <= w_cout;
                  r_flags.overflow  <= w_ovf;
                  r_flags.zero      <= (w_final == '0);
                  r_flags.negative  <= w_final[WIDTH-1];
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign result   = r_result;
   assign cout     = r_flags.cout;
   assign overflow = r_flags.overflow;
   assign zero     = r_flags.zero;
   assign negative = r_flags.negative;

endmodule

`default_nettype wire
